// File: rtl/charmatrix_pixel_streamer_if.sv
// Pixel stream towards the WS2812B driver: one 24-bit GRB word per LED, latch flag on the frame's last pixel.
// Transfer occurs when pix_valid & pix_ready are both high at a rising clk20 edge.
interface charmatrix_pixel_streamer_if;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_latch;
    logic        pix_ready;

    modport master (
        output pix_data,
        output pix_valid,
        output pix_latch,
        input  pix_ready
    );

    modport slave (
        input  pix_data,
        input  pix_valid,
        input  pix_latch,
        output pix_ready
    );
endinterface

// File: rtl/charmatrix_pixel_streamer.sv
// Scans a ROWS x COLS one-bit bitmap into fg/bg colour words, one per LED; optional SERPENTINE_EN reverses odd rows.
// Latency: refresh at edge t -> first pixel valid after edge t+1; one idle cycle between pixels.
// Backpressure: pixel held stable while pix_ready is low; refresh while busy queues one pending frame.
module charmatrix_pixel_streamer #(
    parameter  int COLS = 8,
    parameter  int ROWS = 8,
    localparam int N    = ROWS * COLS,
    localparam int IW   = (N > 1) ? $clog2(N) : 1,
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                clk20,
    input  logic                reset,
    input  logic                row_we,
    input  logic [RW-1:0]       row_addr,
    input  logic [COLS-1:0]     row_data,
    input  logic [23:0]         fg_color,
    input  logic [23:0]         bg_color,
    input  logic                refresh,
    output logic                busy,
    charmatrix_pixel_streamer_if.master pix
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   index_q;
    logic            busy_q;
    logic            pending_q;
    logic [23:0]     fg_snap_q;
    logic [23:0]     bg_snap_q;
    logic [23:0]     pix_data_q;
    logic            pix_valid_q;
    logic            pix_latch_q;
    logic [COLS-1:0] bitmap_q [ROWS];

    int              row_i;
    int              col_i;
    logic [RW-1:0]   row_sel;
    logic [CW-1:0]   col_sel;
    logic            pix_bit;
    logic            last_idx;

    // Integer arithmetic avoids truncating COLS when the whole frame is a single row.
    always_comb begin
        row_i = int'(index_q) / COLS;
        col_i = int'(index_q) % COLS;
`ifdef SERPENTINE_EN
        if (row_i[0]) begin
            col_i = COLS - 1 - col_i;
        end
`endif
        row_sel  = row_i[RW-1:0];
        col_sel  = col_i[CW-1:0];
        pix_bit  = bitmap_q[row_sel][col_sel];
        last_idx = (index_q == IW'(N - 1));
    end

    always_ff @(posedge clk20 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ROWS; i++) begin
                bitmap_q[i] <= '0;
            end
        end else if (row_we && (int'(row_addr) < ROWS)) begin
            bitmap_q[row_addr] <= row_data;
        end
    end

    always_ff @(posedge clk20 or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            index_q     <= '0;
            busy_q      <= 1'b0;
            pending_q   <= 1'b0;
            fg_snap_q   <= '0;
            bg_snap_q   <= '0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            pix_latch_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (refresh || pending_q) begin
                        fg_snap_q <= fg_color;
                        bg_snap_q <= bg_color;
                        index_q   <= '0;
                        busy_q    <= 1'b1;
                        pending_q <= 1'b0;
                        state_q   <= FETCH;
                    end
                end
                FETCH: begin
                    if (refresh) begin
                        pending_q <= 1'b1;
                    end
                    pix_data_q  <= pix_bit ? fg_snap_q : bg_snap_q;
                    pix_latch_q <= last_idx;
                    pix_valid_q <= 1'b1;
                    state_q     <= PRESENT;
                end
                PRESENT: begin
                    if (refresh) begin
                        pending_q <= 1'b1;
                    end
                    if (pix.pix_ready) begin
                        pix_valid_q <= 1'b0;
                        pix_latch_q <= 1'b0;
                        if (last_idx) begin
                            index_q <= '0;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            index_q <= index_q + 1'b1;
                            state_q <= FETCH;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign pix.pix_data  = pix_data_q;
    assign pix.pix_valid = pix_valid_q;
    assign pix.pix_latch = pix_latch_q;

endmodule

// File: tb/tb_charmatrix_pixel_streamer.sv
// Directed bench for charmatrix_pixel_streamer with a 4x2 matrix; honours SERPENTINE_EN for expected scan order.
module tb_charmatrix_pixel_streamer;
    localparam int COLS = 4;
    localparam int ROWS = 2;

    logic        clk20    = 1'b0;
    logic        reset    = 1'b1;
    logic        row_we   = 1'b0;
    logic [0:0]  row_addr = '0;
    logic [3:0]  row_data = '0;
    logic [23:0] fg_color = '0;
    logic [23:0] bg_color = '0;
    logic        refresh  = 1'b0;
    logic        busy;

    charmatrix_pixel_streamer_if pif ();

    charmatrix_pixel_streamer #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk20    (clk20),
        .reset    (reset),
        .row_we   (row_we),
        .row_addr (row_addr),
        .row_data (row_data),
        .fg_color (fg_color),
        .bg_color (bg_color),
        .refresh  (refresh),
        .busy     (busy),
        .pix      (pif)
    );

    always #25 clk20 = ~clk20;

    int          checks   = 0;
    int          failures = 0;
    logic [23:0] got_data [8];
    logic        got_lat  [8];
    logic [23:0] exp_bg   [8];
    logic [23:0] exp_a    [8];
    logic [23:0] exp_b    [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk20);
        #1;
    endtask

    task automatic pulse_refresh();
        refresh = 1'b1;
        step();
        refresh = 1'b0;
    endtask

    // Collects n handed-off pixels into got_data/got_lat starting at slot 'start'.
    task automatic recv(input int start, input int n);
        int cyc;
        for (int k = 0; k < n; k++) begin
            cyc = 0;
            while (!(pif.pix_valid && pif.pix_ready) && cyc < 200) begin
                step();
                cyc++;
            end
            if (cyc >= 200) begin
                chk($sformatf("recv_timeout_%0d", start + k), 32'(cyc), 32'd0);
                return;
            end
            if (k > 0) chk($sformatf("pix_gap_%0d", start + k), 32'(cyc), 32'd1);
            got_data[start + k] = pif.pix_data;
            got_lat[start + k]  = pif.pix_latch;
            step();
        end
    endtask

    task automatic check_frame(input string tag, input logic [23:0] e [8]);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_pix%0d", tag, i), {8'h0, got_data[i]}, {8'h0, e[i]});
            chk($sformatf("%s_latch%0d", tag, i), {31'h0, got_lat[i]}, (i == 7) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] d0;
        logic        l0;
        int          changes;

        for (int i = 0; i < 8; i++) exp_bg[i] = 24'h000011;
`ifdef SERPENTINE_EN
        exp_a = '{24'hFF0000, 24'h000011, 24'h000011, 24'h000011,
                  24'hFF0000, 24'h000011, 24'h000011, 24'h000011};
        exp_b = '{24'h00FF00, 24'h000011, 24'h000011, 24'h000011,
                  24'h00FF00, 24'h000011, 24'h000011, 24'h000011};
`else
        exp_a = '{24'hFF0000, 24'h000011, 24'h000011, 24'h000011,
                  24'h000011, 24'h000011, 24'h000011, 24'hFF0000};
        exp_b = '{24'h00FF00, 24'h000011, 24'h000011, 24'h000011,
                  24'h000011, 24'h000011, 24'h000011, 24'h00FF00};
`endif
        pif.pix_ready = 1'b1;

        // Reset state.
        repeat (3) step();
        chk("rst_valid", {31'h0, pif.pix_valid}, 32'd0);
        chk("rst_data",  {8'h0, pif.pix_data},   32'd0);
        chk("rst_latch", {31'h0, pif.pix_latch}, 32'd0);
        chk("rst_busy",  {31'h0, busy},          32'd0);
        reset = 1'b0;
        step();
        chk("post_rst_busy",  {31'h0, busy},          32'd0);
        chk("post_rst_valid", {31'h0, pif.pix_valid}, 32'd0);

        // Empty bitmap frame.
        fg_color = 24'hFF0000;
        bg_color = 24'h000011;
        pulse_refresh();
        chk("start_busy",  {31'h0, busy},          32'd1);
        chk("start_valid", {31'h0, pif.pix_valid}, 32'd0);
        recv(0, 8);
        check_frame("empty", exp_bg);
        chk("empty_end_busy",  {31'h0, busy},          32'd0);
        chk("empty_end_valid", {31'h0, pif.pix_valid}, 32'd0);

        // Pattern frame.
        row_we = 1'b1; row_addr = 1'b0; row_data = 4'b0001;
        step();
        row_addr = 1'b1; row_data = 4'b1000;
        step();
        row_we = 1'b0;
        pulse_refresh();
        recv(0, 8);
        check_frame("pattern", exp_a);

        // 50-cycle stall mid-frame.
        pulse_refresh();
        recv(0, 2);
        pif.pix_ready = 1'b0;
        step();
        chk("stall_valid", {31'h0, pif.pix_valid}, 32'd1);
        d0 = pif.pix_data;
        l0 = pif.pix_latch;
        changes = 0;
        repeat (50) begin
            step();
            if (pif.pix_valid !== 1'b1 || pif.pix_data !== d0 || pif.pix_latch !== l0) changes++;
        end
        chk("stall_stable", 32'(changes), 32'd0);
        chk("stall_data", {8'h0, d0}, {8'h0, exp_a[2]});
        pif.pix_ready = 1'b1;
        recv(2, 6);
        check_frame("stall", exp_a);

        // Three refresh pulses during a frame -> exactly one extra frame.
        pulse_refresh();
        recv(0, 1);
        pif.pix_ready = 1'b0;
        pulse_refresh();
        step();
        pulse_refresh();
        step();
        pulse_refresh();
        pif.pix_ready = 1'b1;
        recv(1, 7);
        check_frame("merge_f1", exp_a);
        chk("merge_gap_busy_low", {31'h0, busy}, 32'd0);
        step();
        chk("merge_busy_again", {31'h0, busy}, 32'd1);
        recv(0, 8);
        check_frame("merge_f2", exp_a);
        repeat (6) step();
        chk("merge_no_third_busy",  {31'h0, busy},          32'd0);
        chk("merge_no_third_valid", {31'h0, pif.pix_valid}, 32'd0);

        // Foreground colour change mid-frame stays frozen until the next frame.
        pulse_refresh();
        recv(0, 4);
        fg_color = 24'h00FF00;
        recv(4, 4);
        check_frame("oldfg", exp_a);
        pulse_refresh();
        recv(0, 8);
        check_frame("newfg", exp_b);

        // Asynchronous reset while pixel 3 is presented.
        pulse_refresh();
        recv(0, 3);
        step();
        chk("pre_arst_valid", {31'h0, pif.pix_valid}, 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_valid", {31'h0, pif.pix_valid}, 32'd0);
        chk("arst_data",  {8'h0, pif.pix_data},   32'd0);
        chk("arst_latch", {31'h0, pif.pix_latch}, 32'd0);
        chk("arst_busy",  {31'h0, busy},          32'd0);
        #5;
        reset = 1'b0;
        step();
        pulse_refresh();
        recv(0, 8);
        check_frame("after_arst", exp_bg);
        repeat (5) step();
        chk("after_arst_idle", {31'h0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/charmatrix_pixel_streamer.md
# charmatrix_pixel_streamer

Frame scanner that sits directly upstream of the WS2812B bit-serial LED driver. Holds a ROWS×COLS one-bit character/pixel bitmap, maps each bit to a foreground or background 24-bit colour, and streams one colour word per LED over a valid/ready handshake. The last pixel of each frame carries a latch flag so the driver emits its reset/latch gap.

## Interface
Parameters:
- COLS, 8, matrix width in LEDs (≥2)
- ROWS, 8, matrix height in LEDs (≥1); N = ROWS*COLS LEDs; IW = $clog2(N), RW = max(1,$clog2(ROWS))

Ports:
- clk20  in  1  20 MHz system clock
- reset  in  1  asynchronous, active-high reset
- row_we  in  1  write strobe for one bitmap row
- row_addr  in  RW  row index to write (values ≥ ROWS ignored)
- row_data  in  COLS  row bits; bit c = column c
- fg_color  in  24  colour (GRB, MSB first) for bitmap bit 1
- bg_color  in  24  colour for bitmap bit 0
- refresh  in  1  single-cycle request to send one full frame
- busy  out  1  high from accepted refresh until last pixel handed off
- pix_data  out  24  colour word to driver
- pix_valid  out  1  pix_data/pix_latch valid
- pix_latch  out  1  high with the final pixel of a frame
- pix_ready  in  1  driver ready; transfer when pix_valid & pix_ready at a rising edge

## Operation
- Reset: bitmap all 0, pix_data 0, pix_valid 0, pix_latch 0, busy 0, index 0, pending 0, state IDLE.
- States: IDLE, FETCH, PRESENT.
- IDLE: refresh (or pending) → snapshot fg_color/bg_color into internal regs, index←0, busy←1, clear pending, go FETCH.
- FETCH: r = index / COLS, c = index % COLS (physical column per Configuration); pix_data ← bitmap[r][c] ? fg_snap : bg_snap; pix_latch ← (index == N-1); pix_valid ← 1; go PRESENT.
- PRESENT: hold pix_data/pix_latch/pix_valid stable until transfer. On transfer: pix_valid←0, pix_latch←0; if index == N-1 → index←0, busy←0, IDLE; else index←index+1, FETCH.
- refresh while busy: set pending (one deep; extra requests merge). Pending frame starts from IDLE on the cycle after the current frame ends.
- Row write: row_we writes row_data into bitmap[row_addr] at the edge, in any state. Pixels not yet fetched see new data (no tear protection); colours are frozen per frame by the snapshot.
- Write and FETCH of the same row in one cycle: FETCH uses the old row value.
- Index never exceeds N-1; wrap to 0 only at frame end.

## Timing
- refresh sampled at edge t (IDLE) → FETCH during t..t+1, pix_valid high after edge t+1; busy high after edge t.
- Transfer at edge k → pix_valid low for exactly one cycle, next pixel valid after edge k+1.
- Frame end: busy falls at the edge of the last transfer; with pending set, busy is re-asserted at the following edge (one cycle low).
- pix_valid never drops without a transfer; pix_data never changes while pix_valid & !pix_ready.
- Asynchronous reset mid-frame: outputs return to reset values immediately; pending and bitmap cleared; driver side sees pix_valid fall.

## Configuration
- SERPENTINE_EN defined: odd rows reversed, physical c = COLS-1-(index % COLS) for odd r; matches zig-zag wired matrices.
- Undefined: all rows scanned left-to-right, c = index % COLS.

## Test plan
- Reset with COLS=4, ROWS=2, pix_ready=1 → all outputs 0, busy 0; a refresh with empty bitmap yields 8 transfers of bg_color, latch only on the 8th.
- Write row0=4'b0001, row1=4'b1000, fg=24'hFF0000, bg=24'h000011, refresh → without SERPENTINE_EN pixels FF0000,11,11,11,11,11,11,FF0000; with SERPENTINE_EN pixels FF0000,11,11,11,FF0000,11,11,11.
- pix_ready held low 50 cycles mid-frame → pix_valid, pix_data, pix_latch constant; resume produces no skipped or duplicated pixel.
- Three refresh pulses during a frame → exactly two frames sent back-to-back, busy low for exactly one cycle between them.
- Change fg_color mid-frame → remaining pixels of that frame use the old colour; next frame uses the new one.
- Assert reset at pixel 3 → outputs 0 same cycle; next refresh restarts at index 0 with cleared bitmap (all bg_color).
